udp_axil_slave_regs: RTL and testbench

AXI4-Lite slave register bank forming the responder end of the S00_AXI control interface of the UDP_v3 peripheral. It accepts single-beat writes and reads from the AXI master (VIP in simulation, PS interconnect in hardware) and exposes the register contents and per-register write pulses to the UDP datapath. Write and read channels run independently.

---
 rtl/udp_axil_pkg.sv | 18 +
 rtl/udp_axil_wr_capture.sv | 83 ++++++++
 rtl/udp_axil_slave_regs.sv | 151 +++++++++++++++
 tb/tb_udp_axil_slave_regs.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_axil_pkg.sv
// Shared constants for the UDP_v3 S00_AXI control register bank.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   REG_W / STRB_W          : register width and byte-strobe width
//   REG0_OFF..REG3_OFF      : byte offsets of the implemented registers
package udp_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_W  = 32;
    localparam int STRB_W = 4;

    localparam int unsigned REG0_OFF = 32'h0;
    localparam int unsigned REG1_OFF = 32'h4;
    localparam int unsigned REG2_OFF = 32'h8;
    localparam int unsigned REG3_OFF = 32'hC;

endpackage

// File: rtl/udp_axil_wr_capture.sv
// Write-side front end of the AXI4-Lite slave: independent AW and W capture
// latches plus registered ready generation.
//   clk, rst              : clock, asynchronous active-high reset
//   awaddr/awvalid/awready: AW channel
//   wdata/wstrb/wvalid/wready : W channel
//   bvalid                : current B-channel state from the top (blocks new captures)
//   commit                : combinational, high in the cycle whose edge commits a write
//   addr/data/strb        : write payload to use on the commit edge
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; valid is never withdrawn by this block's
// outputs and ready may be high before valid arrives.
module udp_axil_wr_capture
    import udp_axil_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [REG_W-1:0]  wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    input  logic              bvalid,
    output logic              commit,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  data,
    output logic [STRB_W-1:0] strb
);

    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] addr_q;
    logic [REG_W-1:0]  data_q;
    logic [STRB_W-1:0] strb_q;

    logic aw_hs;
    logic w_hs;
    logic aw_held_next;
    logic w_held_next;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A channel is satisfied if it was captured earlier or is handshaking now.
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    // On the commit edge the payload comes from the latch if held, else the bus.
    assign addr = aw_held ? addr_q : awaddr;
    assign data = w_held ? data_q : wdata;
    assign strb = w_held ? strb_q : wstrb;

    assign aw_held_next = commit ? 1'b0 : (aw_held || aw_hs);
    assign w_held_next  = commit ? 1'b0 : (w_held || w_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
        end else begin
            aw_held <= aw_held_next;
            w_held  <= w_held_next;
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            // bvalid is the pre-edge value, so readies return one edge after
            // the B handshake; commit keeps them low across the commit edge.
            awready <= !aw_held_next && !bvalid && !commit;
            wready  <= !w_held_next && !bvalid && !commit;
        end
    end

endmodule

// File: rtl/udp_axil_slave_regs.sv
// AXI4-Lite slave register bank for the UDP_v3 S00_AXI control interface.
//   ACLK, ARESET         : clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* : write address / data channels (captured in udp_axil_wr_capture)
//   S_AXI_B*             : write response channel
//   S_AXI_AR* / S_AXI_R* : read address / data channels
//   reg_q                : flattened register contents, reg i at [32i+31:32i]
//   reg_wr               : one-cycle pulse per register on each committed write
// Word index is ADDR[ADDR_W-1:2]; indices >= NUM_REGS answer SLVERR.
module udp_axil_slave_regs
    import udp_axil_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_W-1:0]         S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]       S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_W-1:0]         S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [NUM_REGS*REG_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]       reg_wr
);

    localparam int IDX_W = ADDR_W - 2;

    logic [REG_W-1:0] regs [NUM_REGS];

    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [REG_W-1:0]  wr_data;
    logic [STRB_W-1:0] wr_strb;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [REG_W-1:0] rd_data;
    logic             ar_hs;

    // Protection bits and byte-offset bits carry no meaning for this bank.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    udp_axil_wr_capture #(
        .ADDR_W (ADDR_W)
    ) u_wr_capture (
        .clk     (ACLK),
        .rst     (ARESET),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bvalid  (S_AXI_BVALID),
        .commit  (commit),
        .addr    (wr_addr),
        .data    (wr_data),
        .strb    (wr_strb)
    );

    assign wr_idx      = wr_addr[ADDR_W-1:2];
    assign rd_idx      = S_AXI_ARADDR[ADDR_W-1:2];
    assign wr_in_range = 32'(wr_idx) < 32'(NUM_REGS);
    assign rd_in_range = 32'(rd_idx) < 32'(NUM_REGS);
    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

    // Read mux; out-of-range indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*REG_W +: REG_W] = regs[g];
    end

    // Register array and write strobes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (commit && wr_in_range) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == IDX_W'(i)) begin
                        reg_wr[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // B channel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // Read channel. Reads sample regs before any same-edge write lands.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            // Pre-edge RVALID delays ARREADY by one edge after the R handshake.
            S_AXI_ARREADY <= !S_AXI_RVALID && !ar_hs;
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_axil_slave_regs.sv
// Directed bench for udp_axil_slave_regs. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_udp_axil_slave_regs;
    import udp_axil_pkg::*;

    logic         clk;
    logic         rst;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_regs [4];
    int          exp_cnt  [4];
    int          wr_cnt   [4];
    logic [1:0]  resp;

    udp_axil_slave_regs dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_q         (reg_q),
        .reg_wr        (reg_wr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reg_wr pulse counter
    initial for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (reg_wr[i]) wr_cnt[i]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], exp_regs[i]);
            check($sformatf("%s_wrcnt%0d", tag, i), 32'(wr_cnt[i]), 32'(exp_cnt[i]));
        end
    endtask

    // Entered and left on a falling edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int   n;
        logic aw_done, w_done, aw_fire, w_fire;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_timeout", {31'b0, bvalid}, 32'd1);
        r = bresp;
        @(negedge clk);
    endtask

    // Compares RDATA against the front of exp_q.
    task automatic axi_read(input logic [5:0] a, input logic [1:0] exp_resp);
        int          n;
        logic [31:0] exp;
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("r_timeout", {31'b0, rvalid}, 32'd1);
        exp = exp_q.pop_front();
        check($sformatf("rdata_a%02h", a), rdata, exp);
        check($sformatf("rresp_a%02h", a), {30'b0, rresp}, {30'b0, exp_resp});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) begin exp_regs[i] = '0; exp_cnt[i] = 0; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready",  {31'b0, wready},  32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid",  {31'b0, bvalid},  32'd0);
        check("rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check_regs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rel_awready", {31'b0, awready}, 32'd1);
        check("rel_wready",  {31'b0, wready},  32'd1);
        check("rel_arready", {31'b0, arready}, 32'd1);

        // Basic writes 1..4 then readback
        axi_write(6'(REG0_OFF), 32'h1, 4'hF, resp); check("bresp_w0", {30'b0, resp}, {30'b0, RESP_OKAY});
        axi_write(6'(REG1_OFF), 32'h2, 4'hF, resp); check("bresp_w1", {30'b0, resp}, {30'b0, RESP_OKAY});
        axi_write(6'(REG2_OFF), 32'h3, 4'hF, resp); check("bresp_w2", {30'b0, resp}, {30'b0, RESP_OKAY});
        axi_write(6'(REG3_OFF), 32'h4, 4'hF, resp); check("bresp_w3", {30'b0, resp}, {30'b0, RESP_OKAY});
        exp_regs[0] = 32'h1; exp_regs[1] = 32'h2; exp_regs[2] = 32'h3; exp_regs[3] = 32'h4;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 1;
        check_regs("basic");
        exp_q.push_back(32'h1); axi_read(6'(REG0_OFF), RESP_OKAY);
        exp_q.push_back(32'h2); axi_read(6'(REG1_OFF), RESP_OKAY);
        exp_q.push_back(32'h3); axi_read(6'(REG2_OFF), RESP_OKAY);
        exp_q.push_back(32'h4); axi_read(6'(REG3_OFF), RESP_OKAY);

        // Byte strobes
        axi_write(6'(REG1_OFF), 32'hFFFF_FFFF, 4'hF, resp);
        axi_write(6'(REG1_OFF), 32'h0000_00AB, 4'b0001, resp);
        check("bresp_strb", {30'b0, resp}, {30'b0, RESP_OKAY});
        exp_regs[1] = 32'hFFFF_FFAB; exp_cnt[1] = 3;
        exp_q.push_back(32'hFFFF_FFAB); axi_read(6'(REG1_OFF), RESP_OKAY);

        // W three cycles ahead of AW
        repeat (2) @(negedge clk);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        check("wfirst_wready0", {31'b0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready1", {31'b0, wready}, 32'd0);
        check("wfirst_awready1", {31'b0, awready}, 32'd1);
        @(negedge clk);
        check("wfirst_awready2", {31'b0, awready}, 32'd1);
        check("wfirst_bvalid2", {31'b0, bvalid}, 32'd0);
        @(negedge clk);
        awaddr = 6'(REG2_OFF); awvalid = 1'b1;
        check("wfirst_awready3", {31'b0, awready}, 32'd1);
        check("wfirst_bvalid3", {31'b0, bvalid}, 32'd0);
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_bvalid4", {31'b0, bvalid}, 32'd1);
        check("wfirst_bresp4", {30'b0, bresp}, {30'b0, RESP_OKAY});
        @(negedge clk);
        check("wfirst_bvalid5", {31'b0, bvalid}, 32'd0);
        exp_regs[2] = 32'h55; exp_cnt[2] = 2;
        exp_q.push_back(32'h55); axi_read(6'(REG2_OFF), RESP_OKAY);

        // Out-of-range write and read
        axi_write(6'h20, 32'hDEAD_BEEF, 4'hF, resp);
        check("bresp_oor", {30'b0, resp}, {30'b0, RESP_SLVERR});
        exp_q.push_back(32'h0); axi_read(6'h3C, RESP_SLVERR);
        check_regs("oor");

        // BREADY held low
        repeat (2) @(negedge clk);
        awaddr = 6'(REG3_OFF); wdata = 32'hA5A5_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bhold_bvalid%0d", k), {31'b0, bvalid}, 32'd1);
            check($sformatf("bhold_bresp%0d", k), {30'b0, bresp}, {30'b0, RESP_OKAY});
            check($sformatf("bhold_awready%0d", k), {31'b0, awready}, 32'd0);
            check($sformatf("bhold_wready%0d", k), {31'b0, wready}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bhold_bvalid_clr", {31'b0, bvalid}, 32'd0);
        check("bhold_awready_lag", {31'b0, awready}, 32'd0);
        @(negedge clk);
        check("bhold_awready_back", {31'b0, awready}, 32'd1);
        check("bhold_wready_back", {31'b0, wready}, 32'd1);
        exp_regs[3] = 32'hA5A5_0000; exp_cnt[3] = 2;
        check_regs("bhold");

        // RREADY held low
        araddr = 6'(REG1_OFF); arvalid = 1'b1; rready = 1'b0;
        check("rhold_arready0", {31'b0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rhold_rvalid%0d", k), {31'b0, rvalid}, 32'd1);
            check($sformatf("rhold_rdata%0d", k), rdata, 32'hFFFF_FFAB);
            check($sformatf("rhold_arready%0d", k), {31'b0, arready}, 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check("rhold_rvalid_clr", {31'b0, rvalid}, 32'd0);
        check("rhold_arready_lag", {31'b0, arready}, 32'd0);
        @(negedge clk);
        check("rhold_arready_back", {31'b0, arready}, 32'd1);

        // Unaligned read maps to its word
        exp_q.push_back(32'h55); axi_read(6'h09, RESP_OKAY);

        // Same-edge read and write of reg 0: read sees the old value
        @(negedge clk);
        awaddr = 6'(REG0_OFF); wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 6'(REG0_OFF); arvalid = 1'b1; rready = 1'b1;
        check("same_ready", {29'b0, awready, wready, arready}, 32'd7);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_rvalid", {31'b0, rvalid}, 32'd1);
        check("same_rdata_old", rdata, 32'h1);
        check("same_bvalid", {31'b0, bvalid}, 32'd1);
        @(negedge clk);
        exp_regs[0] = 32'h77; exp_cnt[0] = 2;
        check_regs("same");
        exp_q.push_back(32'h77); axi_read(6'(REG0_OFF), RESP_OKAY);

        // Reset with AW held and no W
        repeat (2) @(negedge clk);
        awaddr = 6'(REG1_OFF); awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("abort_awheld", {31'b0, awready}, 32'd0);
        check("abort_wready", {31'b0, wready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_regs[i] = '0;
        check_regs("abort_rst");
        rst = 1'b0;
        @(negedge clk);
        check("abort_awready", {31'b0, awready}, 32'd1);
        check("abort_wready2", {31'b0, wready}, 32'd1);
        check("abort_arready", {31'b0, arready}, 32'd1);
        wdata = 32'hDEAD; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_bvalid%0d", k), {31'b0, bvalid}, 32'd0);
            @(negedge clk);
        end
        check_regs("abort_post");
        exp_q.push_back(32'h0); axi_read(6'(REG0_OFF), RESP_OKAY);
        exp_q.push_back(32'h0); axi_read(6'(REG1_OFF), RESP_OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
